top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_top.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top: UART baud generator, transmitter and receiver with internal loopback.
// The transmitter's serial line feeds the receiver directly, so the block has
// no serial pins: a byte presented on i_data comes back out on o_data.
//
// Ports
//   i_clock        single clock (50 MHz nominal)
//   i_reset        asynchronous, active-high reset
//   i_tx_start     level request to transmit i_data
//   i_data         byte to transmit (captured when a frame starts)
//   o_data         last byte received; holds until the next good frame
//   o_rx_done_tick one-clock pulse when a frame has been received
//   o_tx_done_tick one-clock pulse when a frame has been transmitted
//
// Configuration
//   UART_PARITY_EN  when defined, both FSMs insert an even-parity bit between
//                   the data bits and the stop bit. A receiver parity mismatch
//                   suppresses o_rx_done_tick and leaves o_data unchanged.
// -----------------------------------------------------------------------------
module top #(
  parameter int DBIT     = 8,    // data bits per frame
  parameter int NB_STATE = 2,    // FSM state register width
  parameter int SB_TICK  = 16,   // stop-bit length in baud ticks
  parameter int BAUD_DIV = 163   // clocks per baud tick
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick,
  output logic            o_tx_done_tick
);

`ifdef UART_PARITY_EN
  // Five states need at least three bits.
  localparam int ST_W = (NB_STATE < 3) ? 3 : NB_STATE;
  typedef enum logic [ST_W-1:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  localparam int ST_W = NB_STATE;
  typedef enum logic [ST_W-1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;  // baud counter
  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;   // tick counter
  localparam int NW = $clog2(DBIT + 1);                       // bit counter

  // ---------------------------------------------------------------- baud gen
  logic [CW-1:0] baud_q, baud_d;
  logic          tick;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    tick   = (baud_q == CW'(BAUD_DIV - 1));
    baud_d = tick ? '0 : baud_q + 1'b1;
  end

  // ------------------------------------------------------------- transmitter
  state_e          tx_state_q, tx_state_d;
  logic [TW-1:0]   tx_s_q, tx_s_d;
  logic [NW-1:0]   tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_q, tx_d;          // serial line, registered glitch-free
  logic            tx_done_q, tx_done_d;
`ifdef UART_PARITY_EN
  logic            tx_par_q, tx_par_d;  // even parity of the captured byte
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          tx_state_d = S_START;
          tx_s_d     = '0;
          tx_b_d     = i_data;
`ifdef UART_PARITY_EN
          tx_par_d   = ^i_data;
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (tx_s_q == TW'(15)) begin
            tx_state_d = S_DATA;
            tx_s_d     = '0;
            tx_n_d     = '0;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        tx_d = tx_b_q[0];
        if (tick) begin
          if (tx_s_q == TW'(15)) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_d = S_PARITY;
`else
              tx_state_d = S_STOP;
`endif
            end else begin
              tx_n_d = tx_n_q + 1'b1;
            end
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        tx_d = tx_par_q;
        if (tick) begin
          if (tx_s_q == TW'(15)) begin
            tx_state_d = S_STOP;
            tx_s_d     = '0;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (tx_s_q == TW'(SB_TICK - 1)) begin
            tx_state_d = S_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- receiver
  logic            rx_line;
  state_e          rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            rx_done_q, rx_done_d;
`ifdef UART_PARITY_EN
  logic            rx_perr_q, rx_perr_d;
`endif

  assign rx_line = tx_q;  // internal loopback

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    data_d     = data_q;
    rx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_line) begin
          rx_state_d = S_START;
          rx_s_d     = '0;
`ifdef UART_PARITY_EN
          rx_perr_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        // Re-check the line at the start-bit centre to reject glitches.
        if (tick) begin
          if (rx_s_q == TW'(7)) begin
            rx_state_d = rx_line ? S_IDLE : S_DATA;
            rx_s_d     = '0;
            rx_n_d     = '0;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (rx_s_q == TW'(15)) begin
            rx_s_d = '0;
            rx_b_d = {rx_line, rx_b_q[DBIT-1:1]};
            if (rx_n_q == NW'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_d = S_PARITY;
`else
              rx_state_d = S_STOP;
`endif
            end else begin
              rx_n_d = rx_n_q + 1'b1;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (rx_s_q == TW'(15)) begin
            rx_state_d = S_STOP;
            rx_s_d     = '0;
            rx_perr_d  = rx_line ^ (^rx_b_q);
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (rx_s_q == TW'(SB_TICK - 1)) begin
            rx_state_d = S_IDLE;
`ifdef UART_PARITY_EN
            if (!rx_perr_q) begin
              data_d    = rx_b_q;
              rx_done_d = 1'b1;
            end
`else
            data_d    = rx_b_q;
            rx_done_d = 1'b1;
`endif
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------- registers
  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      baud_q     <= '0;
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      rx_state_q <= S_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      data_q     <= '0;
      rx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      baud_q     <= baud_d;
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      data_q     <= data_d;
      rx_done_q  <= rx_done_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign o_data         = data_q;
  assign o_rx_done_tick = rx_done_q;
  assign o_tx_done_tick = tx_done_q;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top: directed bench for the loopback UART. One instance runs with the
// default 163-clock baud divider for a single 0xAA frame; a second instance
// with BAUD_DIV = 4 carries the remaining frames so the run stays short.
// -----------------------------------------------------------------------------
module tb_top;
  localparam int BD = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME = 176;
`else
  localparam int FRAME = 160;
`endif
  localparam int FCLK  = FRAME * BD;
  localparam int DFCLK = FRAME * 163;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, d_start;
  logic [7:0] data, d_data;
  logic [7:0] o_data, d_o_data;
  logic       rx_done, tx_done, d_rx_done, d_tx_done;

  always #5 clk = ~clk;

  top #(.BAUD_DIV(BD)) dut (
    .i_clock(clk), .i_reset(rst), .i_tx_start(start), .i_data(data),
    .o_data(o_data), .o_rx_done_tick(rx_done), .o_tx_done_tick(tx_done)
  );

  top dut_def (
    .i_clock(clk), .i_reset(rst), .i_tx_start(d_start), .i_data(d_data),
    .o_data(d_o_data), .o_rx_done_tick(d_rx_done), .o_tx_done_tick(d_tx_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int rx_cnt = 0, tx_cnt = 0, rx_time = 0, tx_time = 0;
  int run_rx = 0, run_tx = 0, max_rx = 0, max_tx = 0;
  int d_rx_cnt = 0, d_tx_cnt = 0, d_rx_time = 0, d_tx_time = 0;
  logic [7:0] rx_data = '0, d_rx_data = '0;

  always @(negedge clk) begin
    if (rx_done) begin rx_cnt++; rx_time = cyc; rx_data = o_data; end
    if (tx_done) begin tx_cnt++; tx_time = cyc; end
    run_rx = rx_done ? run_rx + 1 : 0;
    run_tx = tx_done ? run_tx + 1 : 0;
    if (run_rx > max_rx) max_rx = run_rx;
    if (run_tx > max_tx) max_tx = run_tx;
    if (d_rx_done) begin d_rx_cnt++; d_rx_time = cyc; d_rx_data = d_o_data; end
    if (d_tx_done) begin d_tx_cnt++; d_tx_time = cyc; end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_sample();
    @(negedge clk);
    #1;
  endtask

  // Pulse i_tx_start for one clock with byte v, wait for the frame and check
  // data, counts, start-to-done latency and rx-before-tx offset.
  task automatic send(input logic [7:0] v, input string tag);
    int rx0, tx0, c_start, lat, off;
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    data = v;
    @(negedge clk);
    start   = 1'b1;
    c_start = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < FCLK + 200 && tx_cnt < tx0 + 1; i++) tick_sample();
    check({tag, "_tx_cnt"}, tx_cnt, tx0 + 1);
    check({tag, "_rx_cnt"}, rx_cnt, rx0 + 1);
    check({tag, "_data"}, rx_data, v);
    lat = tx_time - c_start;
    check({tag, "_latency_ok"}, int'(lat >= FCLK - 4 && lat <= FCLK + 4), 1);
    off = tx_time - rx_time;
    check({tag, "_rx_lead_ok"}, int'(off >= 7 * BD - 2 && off <= 8 * BD + 2), 1);
  endtask

  initial begin
    int off, tx0, rx0, prev_t;
    rst = 1'b1; start = 1'b0; data = '0; d_start = 1'b0; d_data = '0;
    #1000;
    tick_sample();
    check("rst_o_data", o_data, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_d_o_data", d_o_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Default divider: one 0xAA frame.
    d_data = 8'hAA;
    @(negedge clk);
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    for (int i = 0; i < DFCLK + 1000 && d_tx_cnt < 1; i++) tick_sample();
    check("def_tx_cnt", d_tx_cnt, 1);
    check("def_rx_cnt", d_rx_cnt, 1);
    check("def_data", d_rx_data, 8'hAA);
    off = d_tx_time - d_rx_time;
    check("def_rx_lead_ok", int'(off >= 7 * 163 - 2 && off <= 8 * 163 + 2), 1);

    // Fast divider: all-zeros and all-ones bytes.
    send(8'h00, "b00");
    send(8'hFF, "bff");

    // Back-to-back frames with i_tx_start held high.
    tx0 = tx_cnt;
    rx0 = rx_cnt;
    prev_t = 0;
    data = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4 * FCLK + 500 && tx_cnt < tx0 + 3; i++) begin
      int seen;
      seen = tx_cnt;
      tick_sample();
      if (tx_cnt != seen) begin
        check("b2b_data", rx_data, 8'h5A);
        check("b2b_rx_cnt", rx_cnt, rx0 + (tx_cnt - tx0));
        if (tx_cnt > tx0 + 1) check("b2b_period", tx_time - prev_t, FCLK);
        prev_t = tx_time;
        if (tx_cnt == tx0 + 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_tx_cnt", tx_cnt, tx0 + 3);

    // Reset in the middle of the data bits of a 0x55 frame.
    tx0 = tx_cnt;
    rx0 = rx_cnt;
    data = 8'h55;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100 * BD) @(negedge clk);
    rst = 1'b1;
    tick_sample();
    check("midrst_o_data", o_data, 0);
    check("midrst_rx_done", rx_done, 0);
    check("midrst_tx_done", tx_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FCLK) @(negedge clk);
    check("midrst_tx_quiet", tx_cnt, tx0);
    check("midrst_rx_quiet", rx_cnt, rx0);
    check("midrst_o_data_hold", o_data, 0);

    send(8'h3C, "b3c");
    send(8'h07, "b07");

    check("rx_pulse_width", max_rx, 1);
    check("tx_pulse_width", max_tx, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
